// File: rtl/riscv_mem_checker_if.sv
// rtl/riscv_mem_checker_if.sv - read port between the memory checker and the data memory
interface riscv_mem_checker_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/riscv_mem_checker.sv
// rtl/riscv_mem_checker.sv - table-driven data-memory checker
// Reads memory at programmed cycles after run and compares masked little-endian words.
module riscv_mem_checker #(
  parameter int NB_TESTS    = 32,
  parameter int CYC_W       = 32,
  parameter int PIPE_OFFSET = 4,
  localparam int IDX_W      = (NB_TESTS > 1) ? $clog2(NB_TESTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [CYC_W-1:0]    cfg_cyc,
  input  logic [31:0]         cfg_addr,
  input  logic [1:0]          cfg_size,
  input  logic [31:0]         cfg_value,
  input  logic [IDX_W:0]      ntests,
  input  logic                run,
  riscv_mem_checker_if.master mrd,
  output logic                busy,
  output logic                all_done,
  output logic [IDX_W:0]      done_cnt,
  output logic [IDX_W:0]      pass_cnt,
  output logic                fail,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic                err_size,
  output logic                late
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CMP, S_DONE} state_t;
  state_t state, state_nx;

  localparam logic [CYC_W-1:0] OFFSET = CYC_W'(PIPE_OFFSET);

  logic [CYC_W-1:0] cyc_tab  [NB_TESTS];
  logic [31:0]      addr_tab [NB_TESTS];
  logic [1:0]       size_tab [NB_TESTS];
  logic [31:0]      val_tab  [NB_TESTS];

  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] target;
  logic [IDX_W:0]   idx;
  logic [IDX_W:0]   ntests_q;
  logic [IDX_W-1:0] cur;
  logic [31:0]      rd_data;
  logic [31:0]      mask;
  logic             idle_like;
  logic             start;
  logic             pass;
  logic             size_bad;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign start     = run && idle_like;
  assign cur       = idx[IDX_W-1:0];
  assign target    = cyc_tab[cur] + OFFSET;

  // Table survives rst so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    if (cfg_we && idle_like) begin
      cyc_tab[cfg_idx]  <= cfg_cyc;
      addr_tab[cfg_idx] <= cfg_addr;
      size_tab[cfg_idx] <= cfg_size;
      val_tab[cfg_idx]  <= cfg_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (run) state_nx = (ntests == '0) ? S_DONE : S_WAIT;
      S_WAIT:         if (cyc_cnt >= target) state_nx = S_READ;
      S_READ:         if (mrd.ack) state_nx = S_CMP;
      S_CMP:          state_nx = (idx + 1'b1 == ntests_q) ? S_DONE : S_WAIT;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mrd.req  = 1'b0;
    mrd.addr = 32'h0;
    busy     = 1'b0;
    all_done = 1'b0;
    case (state)
      S_WAIT, S_CMP: busy = 1'b1;
      S_READ: begin
        busy     = 1'b1;
        mrd.req  = 1'b1;
        mrd.addr = addr_tab[cur];
      end
      S_DONE:  all_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mask = 32'h0;
    case (size_tab[cur])
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      2'd2:    mask = 32'hFFFF_FFFF;
      default: mask = 32'h0;
    endcase
  end

  assign size_bad = (size_tab[cur] == 2'd3);
  assign pass     = ((rd_data ^ val_tab[cur]) & mask) == 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt        <= '0;
      idx            <= '0;
      ntests_q       <= '0;
      rd_data        <= 32'h0;
      done_cnt       <= '0;
      pass_cnt       <= '0;
      fail           <= 1'b0;
      first_fail_idx <= '0;
      err_size       <= 1'b0;
      late           <= 1'b0;
    end else if (start) begin
      cyc_cnt        <= '0;
      idx            <= '0;
      ntests_q       <= ntests;
      done_cnt       <= '0;
      pass_cnt       <= '0;
      fail           <= 1'b0;
      first_fail_idx <= '0;
      err_size       <= 1'b0;
      late           <= 1'b0;
    end else begin
      if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
      case (state)
        S_WAIT: if (cyc_cnt > target) late <= 1'b1;
        S_READ: if (mrd.ack) rd_data <= mrd.data;
        S_CMP: begin
          done_cnt <= done_cnt + 1'b1;
          idx      <= idx + 1'b1;
          if (size_bad) begin
            err_size <= 1'b1;
          end else if (pass) begin
            pass_cnt <= pass_cnt + 1'b1;
          end else if (!fail) begin
            fail           <= 1'b1;
            first_fail_idx <= cur;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
